sum_display: RTL and testbench



---
 rtl/sum_display.sv | 137 +++++++++++++
 tb/tb_sum_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sum_display.sv
// Captures a 5-bit adder sum on a valid/ready handshake. It converts the sum to
// BCD with a 5-step sequential double-dabble and scans two seven-segment digits.
module sum_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sum_in,
    input  logic       sum_valid,
    output logic       sum_ready,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       carry_led
);

    localparam int           CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_bcd;
    logic [4:0]    r_bin;
    logic [2:0]    r_step;
    logic          r_cap4;
    logic [3:0]    r_tens, r_ones;
    logic          r_carry;
    logic [CW-1:0] r_scan;
    logic          r_sel;
    logic          w_load, w_done;
    logic [12:0]   w_dd_nxt;
    logic [3:0]    w_digit;
    logic [6:0]    w_glyph;

    // One double-dabble step: adjust each nibble >= 5 by +3, then shift {bcd, bin} left.
    function automatic logic [12:0] dd_step(input logic [7:0] bcd, input logic [4:0] bin);
        logic [3:0] t, o;
        t = bcd[7:4];
        o = bcd[3:0];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t, o, bin} << 1;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        sum_ready   = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                sum_ready = 1'b1;
                if (sum_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (r_step == 3'd4) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_dd_nxt = dd_step(r_bcd, r_bin);

    // After the fifth shift all binary bits have moved into the BCD field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd   <= 8'd0;
            r_bin   <= 5'd0;
            r_step  <= 3'd0;
            r_cap4  <= 1'b0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_carry <= 1'b0;
        end else if (w_load) begin
            r_bcd  <= 8'd0;
            r_bin  <= sum_in;
            r_cap4 <= sum_in[4];
            r_step <= 3'd0;
        end else if (r_state == S_CONV) begin
            {r_bcd, r_bin} <= w_dd_nxt;
            r_step         <= r_step + 3'd1;
            if (w_done) begin
                r_tens  <= w_dd_nxt[12:9];
                r_ones  <= w_dd_nxt[8:5];
                r_carry <= r_cap4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_sel  <= 1'b0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_sel  <= ~r_sel;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    // A leading zero in the tens position is blanked rather than shown.
    assign w_digit   = r_sel ? r_tens : r_ones;
    assign w_glyph   = (r_sel && r_tens == 4'd0) ? 7'h00 : glyph(w_digit);
    assign seg       = SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
    assign dig_en    = r_sel ? 2'b10 : 2'b01;
    assign carry_led = r_carry;

endmodule

// File: tb/tb_sum_display.sv
// Bench for sum_display: reset checks, a table of known sums, and handshake corner
// sequences, followed by random traffic. All of it is checked against a decimal-level model.
module tb_sum_display;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] sum_in = 5'd0;
    logic       sum_valid = 1'b0;
    logic       sum_ready;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       carry_led;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: edges since reset, remaining busy edges, pending and shown value.
    int k      = 0;
    int m_busy = 0;
    int m_pend = 0;
    int m_disp = 0;

    logic [6:0] gly [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [4:0] sum;
        logic [6:0] ones_seg;
        logic [6:0] tens_seg;
        logic       carry;
    } vec_t;

    vec_t tbl [10];

    sum_display #(.REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .seg       (seg),
        .dig_en    (dig_en),
        .carry_led (carry_led)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg();
        int sel, tens, ones;
        sel  = (k / R) % 2;
        tens = m_disp / 10;
        ones = m_disp % 10;
        if (sel == 0)     return ~gly[ones];
        else if (tens == 0) return 7'h7F;
        else              return ~gly[tens];
    endfunction

    task automatic check_model(input string tag);
        logic [6:0] es;
        es = exp_seg();
        chk({tag, ".ready"}, sum_ready, (m_busy == 0));
        chk({tag, ".dig_en"}, dig_en, ((k / R) % 2 == 0) ? 2'b01 : 2'b10);
        chk({tag, ".seg"}, seg, es);
        chk({tag, ".carry"}, carry_led, (m_disp >= 16));
    endtask

    task automatic model_reset();
        k = 0; m_busy = 0; m_pend = 0; m_disp = 0;
    endtask

    task automatic tick(input logic v, input logic [4:0] s, input string tag);
        sum_valid = v;
        sum_in    = s;
        @(posedge clk);
        k++;
        if (m_busy == 0) begin
            if (v) begin
                m_pend = s;
                m_busy = 5;
            end
        end else begin
            m_busy--;
            if (m_busy == 0) m_disp = m_pend;
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".ready"}, sum_ready, 1'b1);
        chk({tag, ".dig_en"}, dig_en, 2'b01);
        chk({tag, ".seg"}, seg, 7'h40);
        chk({tag, ".carry"}, carry_led, 1'b0);
    endtask

    initial begin
        tbl[0] = '{5'd30, 7'h40, 7'h30, 1'b1};
        tbl[1] = '{5'd9,  7'h10, 7'h7F, 1'b0};
        tbl[2] = '{5'd31, 7'h79, 7'h30, 1'b1};
        tbl[3] = '{5'd0,  7'h40, 7'h7F, 1'b0};
        tbl[4] = '{5'd16, 7'h02, 7'h79, 1'b1};
        tbl[5] = '{5'd25, 7'h12, 7'h24, 1'b1};
        tbl[6] = '{5'd10, 7'h40, 7'h79, 1'b0};
        tbl[7] = '{5'd15, 7'h12, 7'h79, 1'b0};
        tbl[8] = '{5'd20, 7'h40, 7'h24, 1'b1};
        tbl[9] = '{5'd18, 7'h00, 7'h79, 1'b1};

        // Reset with no clock running.
        #2 rst = 1'b1;
        #2 check_reset_vals("rst_noclk");
        clk_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_vals("rst_release");

        // Table of known sums: transfer, wait out the conversion, then watch a full scan.
        foreach (tbl[i]) begin
            tick(1'b1, tbl[i].sum, "tbl_xfer");
            for (int j = 0; j < 5; j++) tick(1'b0, 5'($urandom_range(0, 31)), "tbl_conv");
            for (int j = 0; j < 2 * R; j++) begin
                tick(1'b0, 5'd0, "tbl_scan");
                if ((k / R) % 2 == 0) chk("tbl.ones_seg", seg, tbl[i].ones_seg);
                else                  chk("tbl.tens_seg", seg, tbl[i].tens_seg);
                chk("tbl.carry", carry_led, tbl[i].carry);
            end
        end

        // Valid held high: 7 accepted, 12 ignored while converting, then accepted at N+6.
        tick(1'b1, 5'd7, "hold_7");
        for (int j = 0; j < 4; j++) tick(1'b1, 5'd12, "hold_12_busy");
        tick(1'b1, 5'd12, "hold_done7");
        chk("hold.ready_after_7", sum_ready, 1'b1);
        chk("hold.carry_after_7", carry_led, 1'b0);
        tick(1'b1, 5'd12, "hold_accept12");
        chk("hold.ready_low_12", sum_ready, 1'b0);
        for (int j = 0; j < 5; j++) tick(1'b0, 5'd0, "hold_conv12");
        for (int j = 0; j < 2 * R; j++) tick(1'b0, 5'd0, "hold_scan12");

        // Reset in the middle of converting 25, then a clean transfer of 16.
        tick(1'b1, 5'd25, "mid_xfer25");
        for (int j = 0; j < 3; j++) tick(1'b0, 5'd0, "mid_step");
        rst = 1'b1;
        #1 check_reset_vals("mid_rst");
        model_reset();
        #1 rst = 1'b0;
        tick(1'b1, 5'd16, "post_xfer16");
        for (int j = 0; j < 5; j++) tick(1'b0, 5'd0, "post_conv16");
        chk("post.carry16", carry_led, 1'b1);
        for (int j = 0; j < 2 * R; j++) tick(1'b0, 5'd0, "post_scan16");

        // Random traffic against the model.
        for (int j = 0; j < 400; j++)
            tick(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
